// File: rtl/decode_stage.sv
// RV32I decode stage: one output register with valid/ready hand-off and an optional
// register-pending scoreboard (enabled by defining DECODE_SCOREBOARD_EN).
module decode_stage #(
  parameter int unsigned ILLEGAL_TRAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rw,
  output logic [31:0] out_imm,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its payload stable while valid && !ready.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use1;
  logic        w_use2;
  logic        w_rw_raw;
  logic        w_rw;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic        w_stall;
  logic        w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];

  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_rw_raw  = 1'b0;
    w_illegal = 1'b0;
    w_imm     = 32'd0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_imm    = {in_instr[31:12], 12'b0};
        w_rw_raw = 1'b1;
      end
      OPC_JAL: begin
        w_imm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
        w_rw_raw = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
        w_use1   = 1'b1;
        w_rw_raw = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OPC_STORE: begin
        w_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OPC_OP: begin
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_rw_raw = 1'b1;
      end
      default: w_illegal = (ILLEGAL_TRAP != 0);
    endcase
  end

  // Writes to x0 are architecturally discarded, so never claim one.
  assign w_rw     = w_rw_raw && (w_rd != 5'd0);
  assign in_ready = !w_stall && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;

  // Set after clear so a same-cycle set/clear of one index leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_rd] = 1'b0;
    if (w_accept && w_rw) w_pending_nxt[w_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pending <= 32'd0;
    else       r_pending <= w_pending_nxt;
  end

  // Uses the registered pending state only: a retiring write frees the stall next cycle.
  assign w_stall = in_valid && ((w_use1 && r_pending[w_rs1]) || (w_use2 && r_pending[w_rs2]));
`else
  logic w_unused_wb;
  assign w_stall     = 1'b0;
  assign w_unused_wb = ^{wb_valid, wb_rd, w_use1, w_use2};
`endif

  logic        r_out_valid;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_rw;
  logic [31:0] r_imm;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [31:0] r_pc;
  logic        r_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_rw        <= 1'b0;
      r_imm       <= 32'd0;
      r_opcode    <= 7'd0;
      r_funct3    <= 3'd0;
      r_funct7b5  <= 1'b0;
      r_pc        <= 32'd0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_rw        <= w_rw;
      r_imm       <= w_imm;
      r_opcode    <= w_opcode;
      r_funct3    <= in_instr[14:12];
      r_funct7b5  <= in_instr[30];
      r_pc        <= in_pc;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_rw       = r_rw;
  assign out_imm      = r_imm;
  assign out_opcode   = r_opcode;
  assign out_funct3   = r_funct3;
  assign out_funct7b5 = r_funct7b5;
  assign out_pc       = r_pc;
  assign out_illegal  = r_illegal;
endmodule
